// File: rtl/key_debounce_fsm.sv
// Multi-key debouncer: per-key 2-flop synchronizer feeding a 4-state qualify FSM.
// Optional macro KEY_REPEAT_EN adds auto-repeat press pulses while a key stays held.

module key_debounce_lane #(
    parameter int CNT_MAX    = 240000,
    parameter int REPEAT_DLY = 6000000,
    parameter int REPEAT_PER = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic pulse,
    output logic level
);
    localparam int CNT_W = $clog2(CNT_MAX);

    if (CNT_MAX < 2) begin : g_bad_cnt
        $error("CNT_MAX must be at least 2");
    end
    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_rep
        $error("REPEAT_DLY and REPEAT_PER must be at least 1");
    end

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_a, sync_k;
    logic             pulse_d, level_d;
    logic             cnt_done;

    assign cnt_done = (cnt_q == CNT_W'(CNT_MAX - 1));

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_hit;

    // First repeat waits the long delay, later ones the short period
    assign rep_hit = rep_first_q ? (rep_q == REP_W'(REPEAT_DLY - 1))
                                 : (rep_q == REP_W'(REPEAT_PER - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b1;
            sync_k  <= 1'b1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse   <= 1'b0;
            level   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            sync_a  <= key_raw;
            sync_k  <= sync_a;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
            level   <= level_d;
`ifdef KEY_REPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        unique case (state_q)
            RELEASED: begin
                if (!sync_k) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_k) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (sync_k) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef KEY_REPEAT_EN
                else if (rep_hit) begin
                    pulse_d     = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                // Repeat counter is left untouched here so a glitchy release resumes it
                if (!sync_k) begin
                    state_d = PRESSED;
                end else if (cnt_done) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end
endmodule

module key_debounce_fsm #(
    parameter int N          = 3,
    parameter int CNT_MAX    = 240000,
    parameter int REPEAT_DLY = 6000000,
    parameter int REPEAT_PER = 1200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_pulse,
    output logic [N-1:0] key_state
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        key_debounce_lane #(
            .CNT_MAX   (CNT_MAX),
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .key_raw(key[i]),
            .pulse  (key_pulse[i]),
            .level  (key_state[i])
        );
    end
endmodule

// File: tb/tb_key_debounce_fsm.sv
// Bench for key_debounce_fsm: directed latency/bounce/reset cases plus random key
// activity, checked against a run-length reference model of the debouncing rules.

module tb_key_debounce_fsm;
    localparam int N          = 3;
    localparam int CNT_MAX    = 4;
    localparam int REPEAT_DLY = 10;
    localparam int REPEAT_PER = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key = '1;
    logic [N-1:0] key_pulse, key_state;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_debounce_fsm #(
        .N(N), .CNT_MAX(CNT_MAX), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_pulse(key_pulse),
        .key_state(key_state)
    );

    // Reference: raw samples reach the qualifier two edges late; a level flips after
    // CNT_MAX+1 consecutive disagreeing samples, any agreeing sample restarts the run.
    logic [N-1:0] hist1 = '1, hist2 = '1;
    logic [N-1:0] m_lvl = '0, m_pulse = '0;
    int run [N];
    int rep [N];
    bit rep_first [N];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] want);
        checks++;
        if (obs !== want) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, obs, want);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] seen;
        seen    = hist2;
        m_pulse = '0;
        if (rst) begin
            hist1 = '1;
            hist2 = '1;
            m_lvl = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = 0;
                rep[i] = 0;
                rep_first[i] = 1'b1;
            end
        end else begin
            hist2 = hist1;
            hist1 = key;
            for (int i = 0; i < N; i++) begin
                bit press;
                press = !seen[i];
                if (press == m_lvl[i]) begin
`ifdef KEY_REPEAT_EN
                    if (m_lvl[i] && run[i] == 0) begin
                        rep[i]++;
                        if (rep[i] == (rep_first[i] ? REPEAT_DLY : REPEAT_PER)) begin
                            m_pulse[i]   = 1'b1;
                            rep[i]       = 0;
                            rep_first[i] = 1'b0;
                        end
                    end
`endif
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == CNT_MAX + 1) begin
                        m_lvl[i] = press;
                        run[i]   = 0;
                        if (press) begin
                            m_pulse[i]   = 1'b1;
                            rep[i]       = 0;
                            rep_first[i] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pulse", key_pulse, m_pulse);
        chk("state", key_state, m_lvl);
    endtask

    // Runs 7 edges after an input change and checks the fixed pulse latency
    task automatic expect_pulse_at7(input string tag, input logic [N-1:0] want);
        for (int e = 1; e <= 7; e++) begin
            step();
            chk(tag, key_pulse, (e == 7) ? want : '0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            rep[i] = 0;
            rep_first[i] = 1'b1;
        end

        rst = 1'b1;
        key = '1;
        step();
        step();
        chk("reset_state", key_state, '0);
        chk("reset_pulse", key_pulse, '0);
        rst = 1'b0;

        // Single press and hold
        key = 3'b110;
        expect_pulse_at7("press_lat", 3'b001);
        for (int e = 0; e < 5; e++) step();
        chk("press_level", key_state, 3'b001);
        key = '1;
        for (int e = 0; e < 8; e++) step();
        chk("release_level", key_state, '0);

        // Bounce on key 1 before a stable press
        key = 3'b101;
        for (int e = 0; e < 3; e++) step();
        key = 3'b111;
        step();
        key = 3'b101;
        expect_pulse_at7("bounce_lat", 3'b010);
        key = '1;
        for (int e = 0; e < 8; e++) step();

        // All keys together, then release all
        key = 3'b000;
        expect_pulse_at7("simul_lat", 3'b111);
        for (int e = 0; e < 3; e++) step();
        key = '1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("simul_rel", key_state, (e == 7) ? 3'b000 : 3'b111);
            chk("rel_nopulse", key_pulse, '0);
        end

        // Reset while key 0 is held and qualified
        key = 3'b110;
        for (int e = 0; e < 8; e++) step();
        chk("pre_rst_level", key_state, 3'b001);
        rst = 1'b1;
        step();
        chk("rst_clr_state", key_state, '0);
        chk("rst_clr_pulse", key_pulse, '0);
        rst = 1'b0;
        expect_pulse_at7("rst_requal", 3'b001);

`ifdef KEY_REPEAT_EN
        rst = 1'b1;
        key = '1;
        step();
        rst = 1'b0;
        key = 3'b110;
        for (int e = 1; e <= 25; e++) begin
            step();
            chk("repeat", key_pulse,
                (e == 7 || e == 17 || e == 20 || e == 23) ? 3'b001 : 3'b000);
        end
        key = '1;
        for (int e = 0; e < 12; e++) begin
            step();
            chk("repeat_rel", key_pulse, '0);
        end
`endif

        // Random activity: short runs exercise bounces, long runs qualify
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 6) == 0) key[i] = ~key[i];
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/key_debounce_fsm.md
KEY_DEBOUNCE_FSM -- requirements
Module: key_debounce_fsm

Interface
REQ-001 SHALL have parameter N, default 3: number of independent keys.
REQ-002 SHALL have parameter CNT_MAX, default 240000: debounce qualification time in clk cycles (20 ms at 12 MHz); legal range 2 or more.
REQ-003 SHALL have parameter REPEAT_DLY, default 6000000: hold time before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
REQ-004 SHALL have parameter REPEAT_PER, default 1200000: auto-repeat period (used only with KEY_REPEAT_EN).
REQ-005 SHALL have port clk, input, width 1: single clock, rising-edge.
REQ-006 SHALL have port rst, input, width 1: synchronous reset, active-high.
REQ-007 SHALL have port key, input, width N: raw asynchronous buttons, active-low (0 = pressed).
REQ-008 SHALL have port key_pulse, output, width N: one-cycle press strobe per key, registered, to feed the adder's load and calculate controls.
REQ-009 SHALL have port key_state, output, width N: debounced level per key, registered (1 = pressed).

Function
REQ-010 SHALL pass each key bit through a 2-flop synchronizer; sync_k denotes the second flop.
REQ-011 SHALL give each key its own FSM and its own counter, $clog2(CNT_MAX) bits wide; keys SHALL NOT share state.
REQ-012 SHALL implement four FSM states per key: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 In RELEASED, when sync_k = 0: go to PRESS_WAIT and clear cnt to 0.
REQ-014 In PRESS_WAIT, when sync_k = 1: return to RELEASED (bounce rejected), clear cnt, no pulse.
REQ-015 In PRESS_WAIT, when sync_k = 0 and cnt = CNT_MAX-1: go to PRESSED, set key_state to 1, and assert key_pulse for exactly one cycle; otherwise cnt increments.
REQ-016 In PRESSED, when sync_k = 1: go to RELEASE_WAIT and clear cnt.
REQ-017 In RELEASE_WAIT, when sync_k = 0: return to PRESSED, no pulse.
REQ-018 In RELEASE_WAIT, when sync_k = 1 and cnt = CNT_MAX-1: go to RELEASED and set key_state to 0; otherwise cnt increments.
REQ-019 Latency: with key held low from rising edge 1 (the first edge sampling low), key_pulse SHALL be high exactly in the cycle after edge CNT_MAX+3.
REQ-020 cnt SHALL never wrap; a state exit always occurs at CNT_MAX-1.
REQ-021 Release SHALL never generate key_pulse.
REQ-022 Simultaneous qualification on several keys SHALL assert the corresponding key_pulse bits in the same cycle.
REQ-023 A key held continuously SHALL produce exactly one key_pulse (without KEY_REPEAT_EN).

Reset
REQ-024 While rst = 1 at a clk edge: all FSMs go to RELEASED, all counters clear to 0, synchronizer flops set to 1, and key_pulse and key_state clear to 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL abort with no pulse.
REQ-026 A key held through reset release SHALL requalify for the full REQ-019 latency before pulsing.

Configuration
REQ-027 Macro KEY_REPEAT_EN SHALL, when defined, add a per-key repeat counter that is active in PRESSED.
REQ-028 With KEY_REPEAT_EN defined:
- first extra key_pulse occurs REPEAT_DLY cycles after the press pulse;
- further pulses follow every REPEAT_PER cycles while in PRESSED;
- the repeat counter clears on entering PRESSED from PRESS_WAIT;
- the repeat counter holds during RELEASE_WAIT, and no repeat pulses occur in RELEASE_WAIT.
REQ-029 Without KEY_REPEAT_EN: no repeat logic is synthesized, REPEAT_DLY and REPEAT_PER are ignored, and REQ-023 holds.

Verification (sim params: N=3, CNT_MAX=4, REPEAT_DLY=10, REPEAT_PER=3)
REQ-030 Press: key[0] driven low from edge 1 and held -> key_pulse = 3'b001 for one cycle after edge 7, key_state[0] = 1 from then on, no further pulses.
REQ-031 Bounce: key[1] low for 3 cycles, high for 1, then low and held -> no pulse during the bounce, a single pulse 7 edges after the final low, counted from its first sampled edge.
REQ-032 Simultaneous: key[2:0] all driven low on the same edge -> key_pulse = 3'b111 for one cycle; release of all keys -> key_state = 0 after 7 edges, no pulse.
REQ-033 Reset: rst pulsed for 1 cycle while key[0] is held and key_state[0] = 1 -> outputs 0 immediately, then a new pulse 7 edges after rst deasserts.
REQ-034 Repeat (KEY_REPEAT_EN defined): key[0] held -> pulses after edges 7, 17, 20, 23; after release no pulses.
